binary_multiplier: RTL and testbench
====================================

BINARY_MULTIPLIER -- requirements
Module: binary_multiplier

Interface
REQ-001 Parameter: PIPE_STAGES, default 1, output register stages after the combinational multiplier; legal values 1 or 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operands a0..b1 are valid this cycle.
REQ-005 a0  input  1  operand A bit 0 (LSB).
REQ-006 a1  input  1  operand A bit 1 (MSB).
REQ-007 b0  input  1  operand B bit 0 (LSB).
REQ-008 b1  input  1  operand B bit 1 (MSB).
REQ-009 out_valid  output  1  x0..x3 hold a valid product.
REQ-010 x0  output  1  product bit 0 (LSB).
REQ-011 x1  output  1  product bit 1.
REQ-012 x2  output  1  product bit 2.
REQ-013 x3  output  1  product bit 3 (MSB).
REQ-014 zero  output  1  product is zero; present only when BINARY_MULTIPLIER_ZERO_FLAG_EN is defined.

Function
REQ-015 Product P = {x3,x2,x1,x0} SHALL equal the unsigned product {a1,a0} * {b1,b0}, range 0..9, no truncation.
REQ-016 Combinational core SHALL be gate-level: p0=a0&b0; p1=(a1&b0)^(a0&b1); c1=a1&b0&a0&b1; p2=(a1&b1)^c1; p3=a1&b1&c1.
REQ-017 Latency SHALL be exactly PIPE_STAGES cycles from a sampled in_valid=1 to out_valid=1 with the matching product.
REQ-018 Pipeline SHALL accept a new operand set every cycle; no backpressure, no stall.
REQ-019 in_valid SHALL propagate through a valid shift chain of PIPE_STAGES bits alongside the data.
REQ-020 When in_valid=0 is sampled, the data registers SHALL hold their previous value and only the valid bit SHALL advance as 0.
REQ-021 When out_valid=0, x0..x3 SHALL show the last valid product (or reset value), not intermediate values.
REQ-022 Back-to-back operands SHALL produce back-to-back products in order with no bubble.

Reset
REQ-023 While rst=1, all pipeline data registers, valid bits and outputs SHALL be 0 (x0..x3=0, out_valid=0, zero=1 if enabled).
REQ-024 Reset asserted mid-operation SHALL discard all in-flight products immediately, without waiting for a clock edge.
REQ-025 The first in_valid sampled on the first rising edge after rst deasserts SHALL be processed normally.

Configuration
REQ-026 With macro BINARY_MULTIPLIER_ZERO_FLAG_EN defined, output zero SHALL be registered with the product and equal 1 iff P==0.
REQ-027 Without BINARY_MULTIPLIER_ZERO_FLAG_EN, port zero and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 A shared package binary_multiplier_pkg SHALL hold the operand width (2), product width (4), PIPE_STAGES default and a product struct typedef {valid, p[3:0]}.
REQ-029 Sub-module half_adder (a, b -> sum, carry) SHALL implement the p1/c1 and p2/p3 stages; it is instantiated twice.
REQ-030 Pipeline registers SHALL live in binary_multiplier using a generate loop over PIPE_STAGES.

Verification
REQ-031 Exhaustive: all 16 combinations of a1a0,b1b0, one per cycle with in_valid=1 -> each P equals A*B after PIPE_STAGES cycles, e.g. A=3,B=3 -> x3..x0=1001.
REQ-032 A=2,B=3 -> P=0110; A=1,B=0 -> P=0000 and zero=1 (macro defined).
REQ-033 in_valid=1 for A=3,B=2, then in_valid=0 with A=0,B=0 -> out_valid pulses one cycle, x=0110 held afterwards.
REQ-034 rst asserted between edges while A=3,B=3 in flight -> x=0000, out_valid=0 immediately; no product emerges after release.
REQ-035 PIPE_STAGES=2, stream A=1..3,B=3 back-to-back -> out_valid high 3 consecutive cycles starting 2 cycles later, P=0011,0110,1001.

Source files
------------

// File: rtl/binary_multiplier_pkg.sv
// Shared widths, default pipeline depth and the product record carried down the pipeline.
package binary_multiplier_pkg;

    localparam int OPERAND_W       = 2;
    localparam int PRODUCT_W       = 4;
    localparam int PIPE_STAGES_DEF = 1;

    typedef struct packed {
        logic                 valid;
        logic [PRODUCT_W-1:0] p;
    } product_t;

    function automatic logic is_zero(input logic [PRODUCT_W-1:0] p);
        return (p == {PRODUCT_W{1'b0}});
    endfunction

endpackage

// File: rtl/binary_multiplier_if.sv
// Operand/product bundle of the 2x2 multiplier; zero exists only with BINARY_MULTIPLIER_ZERO_FLAG_EN.
interface binary_multiplier_if;

    logic in_valid;
    logic a0;
    logic a1;
    logic b0;
    logic b1;
    logic out_valid;
    logic x0;
    logic x1;
    logic x2;
    logic x3;
`ifdef BINARY_MULTIPLIER_ZERO_FLAG_EN
    logic zero;

    modport master (output in_valid, a0, a1, b0, b1,
                    input  out_valid, x0, x1, x2, x3, zero);
    modport slave  (input  in_valid, a0, a1, b0, b1,
                    output out_valid, x0, x1, x2, x3, zero);
`else
    modport master (output in_valid, a0, a1, b0, b1,
                    input  out_valid, x0, x1, x2, x3);
    modport slave  (input  in_valid, a0, a1, b0, b1,
                    output out_valid, x0, x1, x2, x3);
`endif

endinterface

// File: rtl/binary_multiplier_half_adder.sv
// Single-bit half adder used to fold the partial products of the 2x2 multiplier.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/binary_multiplier.sv
// Pipelined gate-level 2x2 unsigned multiplier; optional zero flag under BINARY_MULTIPLIER_ZERO_FLAG_EN.
module binary_multiplier
    import binary_multiplier_pkg::*;
#(
    parameter int PIPE_STAGES = PIPE_STAGES_DEF
) (
    input logic                clk,
    input logic                rst,
    binary_multiplier_if.slave bus
);

    // Only depths 1 and 2 are meaningful; anything larger collapses to 2.
    localparam int STAGES = (PIPE_STAGES >= 2) ? 2 : 1;

    logic pp_a1b0_s;
    logic pp_a0b1_s;
    logic pp_a1b1_s;
    logic p0_s;
    logic p1_s;
    logic c1_s;
    logic p2_s;
    logic p3_s;

    assign p0_s      = bus.a0 & bus.b0;
    assign pp_a1b0_s = bus.a1 & bus.b0;
    assign pp_a0b1_s = bus.a0 & bus.b1;
    assign pp_a1b1_s = bus.a1 & bus.b1;

    half_adder u_ha_lo (
        .a     (pp_a1b0_s),
        .b     (pp_a0b1_s),
        .sum   (p1_s),
        .carry (c1_s)
    );

    half_adder u_ha_hi (
        .a     (pp_a1b1_s),
        .b     (c1_s),
        .sum   (p2_s),
        .carry (p3_s)
    );

    product_t pipe_s [STAGES+1];

    assign pipe_s[0].valid = bus.in_valid;
    assign pipe_s[0].p     = {p3_s, p2_s, p1_s, p0_s};

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        product_t stage_q;
        product_t stage_d;

        // Valid always advances; data is captured only with a valid product so the output holds.
        always_comb begin
            stage_d       = stage_q;
            stage_d.valid = pipe_s[g].valid;
            if (pipe_s[g].valid) begin
                stage_d.p = pipe_s[g].p;
            end else begin
                stage_d.p = stage_q.p;
            end
        end

        // Stage register with asynchronous clear of data and valid.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign pipe_s[g+1] = stage_q;
    end

    assign bus.out_valid = pipe_s[STAGES].valid;
    assign bus.x0        = pipe_s[STAGES].p[0];
    assign bus.x1        = pipe_s[STAGES].p[1];
    assign bus.x2        = pipe_s[STAGES].p[2];
    assign bus.x3        = pipe_s[STAGES].p[3];

`ifdef BINARY_MULTIPLIER_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag is loaded alongside the final product stage and reads 1 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b1;
        end else if (pipe_s[STAGES-1].valid) begin
            zero_q <= is_zero(pipe_s[STAGES-1].p);
        end else begin
            zero_q <= zero_q;
        end
    end

    assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_binary_multiplier.sv
// Directed bench for binary_multiplier at depths 1 and 2 with a queue-based arithmetic model.
module tb_binary_multiplier;

    logic       clk;
    logic       rst;
    logic       in_v;
    logic [1:0] in_a;
    logic [1:0] in_b;
    bit         run;
    int         checks;
    int         failures;

    binary_multiplier_if if1 ();
    binary_multiplier_if if2 ();

    assign if1.in_valid = in_v;
    assign if1.a0 = in_a[0];
    assign if1.a1 = in_a[1];
    assign if1.b0 = in_b[0];
    assign if1.b1 = in_b[1];
    assign if2.in_valid = in_v;
    assign if2.a0 = in_a[0];
    assign if2.a1 = in_a[1];
    assign if2.b0 = in_b[0];
    assign if2.b1 = in_b[1];

    binary_multiplier #(.PIPE_STAGES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    binary_multiplier #(.PIPE_STAGES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int prod1();
        return int'({if1.x3, if1.x2, if1.x1, if1.x0});
    endfunction

    function automatic int prod2();
        return int'({if2.x3, if2.x2, if2.x1, if2.x0});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each sampled operand set reappears after the pipeline depth; product holds when idle.
    typedef struct {
        bit v;
        int p;
    } smp_t;

    smp_t q1[$];
    smp_t q2[$];
    bit   ev1, ev2;
    int   ep1, ep2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q1.delete();
            q2.delete();
            ev1 = 1'b0;
            ev2 = 1'b0;
            ep1 = 0;
            ep2 = 0;
        end else begin
            smp_t s;
            s.v = in_v;
            s.p = int'(in_a) * int'(in_b);
            q1.push_back(s);
            q2.push_back(s);
            if (q1.size() >= 1) begin
                s   = q1.pop_front();
                ev1 = s.v;
                if (s.v) ep1 = s.p;
            end
            if (q2.size() >= 2) begin
                s   = q2.pop_front();
                ev2 = s.v;
                if (s.v) ep2 = s.p;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model_valid_d1", int'(if1.out_valid), int'(ev1));
            chk("model_prod_d1", prod1(), ep1);
            chk("model_valid_d2", int'(if2.out_valid), int'(ev2));
            chk("model_prod_d2", prod2(), ep2);
`ifdef BINARY_MULTIPLIER_ZERO_FLAG_EN
            chk("model_zero_d1", int'(if1.zero), int'(ep1 == 0));
            chk("model_zero_d2", int'(if2.zero), int'(ep2 == 0));
`endif
        end
    end

    // Present one operand set and wait until the following negedge (depth-1 result visible).
    task automatic apply(input logic v, input int a, input int b);
        in_v = v;
        in_a = 2'(a);
        in_b = 2'(b);
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        run      = 1'b0;
        rst      = 1'b1;
        in_v     = 1'b0;
        in_a     = 2'd0;
        in_b     = 2'd0;
        #1;
        chk("reset_valid_d1", int'(if1.out_valid), 0);
        chk("reset_prod_d1", prod1(), 0);
        chk("reset_valid_d2", int'(if2.out_valid), 0);
        chk("reset_prod_d2", prod2(), 0);
`ifdef BINARY_MULTIPLIER_ZERO_FLAG_EN
        chk("reset_zero_d1", int'(if1.zero), 1);
`endif
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;

        // Exhaustive sweep, one operand pair per cycle.
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                apply(1'b1, a, b);
            end
        end
        chk("sweep_last_3x3_d1", prod1(), 9);

        apply(1'b1, 3, 3);
        chk("lit_3x3_d1", prod1(), 4'b1001);
        apply(1'b1, 2, 3);
        chk("lit_2x3_d1", prod1(), 4'b0110);
        apply(1'b1, 1, 0);
        chk("lit_1x0_d1", prod1(), 4'b0000);
        chk("lit_2x3_d2", prod2(), 4'b0110);
`ifdef BINARY_MULTIPLIER_ZERO_FLAG_EN
        chk("lit_zero_1x0_d1", int'(if1.zero), 1);
`endif

        // Single valid followed by idle cycles: one-cycle pulse, product held.
        apply(1'b1, 3, 2);
        chk("pulse_valid_d1", int'(if1.out_valid), 1);
        chk("pulse_prod_d1", prod1(), 4'b0110);
        apply(1'b0, 0, 0);
        chk("pulse_drop_d1", int'(if1.out_valid), 0);
        chk("pulse_hold_d1", prod1(), 4'b0110);
        apply(1'b0, 0, 0);
        chk("pulse_hold2_d1", prod1(), 4'b0110);

        // Asynchronous reset between edges with 3x3 in flight.
        apply(1'b1, 3, 3);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid_d1", int'(if1.out_valid), 0);
        chk("arst_prod_d1", prod1(), 0);
        chk("arst_valid_d2", int'(if2.out_valid), 0);
        chk("arst_prod_d2", prod2(), 0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 0, 0);
        apply(1'b0, 0, 0);
        chk("arst_no_emerge_d2", int'(if2.out_valid), 0);
        chk("arst_no_emerge_p2", prod2(), 0);

        // First edge after reset release processes its operands.
        apply(1'b1, 1, 1);
        chk("post_rst_valid_d1", int'(if1.out_valid), 1);
        chk("post_rst_prod_d1", prod1(), 4'b0001);
        apply(1'b0, 0, 0);

        // Back-to-back stream through the depth-2 pipeline.
        apply(1'b1, 1, 3);
        chk("stream_pre_d2", int'(if2.out_valid), 0);
        apply(1'b1, 2, 3);
        chk("stream0_valid_d2", int'(if2.out_valid), 1);
        chk("stream0_prod_d2", prod2(), 4'b0011);
        apply(1'b1, 3, 3);
        chk("stream1_valid_d2", int'(if2.out_valid), 1);
        chk("stream1_prod_d2", prod2(), 4'b0110);
        apply(1'b0, 0, 0);
        chk("stream2_valid_d2", int'(if2.out_valid), 1);
        chk("stream2_prod_d2", prod2(), 4'b1001);
        apply(1'b0, 0, 0);
        chk("stream_end_d2", int'(if2.out_valid), 0);
        chk("stream_hold_d2", prod2(), 4'b1001);

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
